wave_seq_ctrl: RTL and testbench
================================

WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of the sample counters and the LFSR.
REQ-002 The block SHALL have parameter LEN_W, default 16: width of the burst length.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begin a burst; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the burst; active in RUN and PAUSE.
REQ-007 The block SHALL have port pause, input, 1 bit: level-sensitive hold; active in RUN and PAUSE.
REQ-008 The block SHALL have port burst_len, input, LEN_W bits: number of samples per burst; captured in LOAD.
REQ-009 The block SHALL have port seed, input, WIDTH bits: LFSR seed; captured in LOAD.
REQ-010 The block SHALL have port busy, output, 1 bit: high in LOAD, RUN and PAUSE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when the burst ends.
REQ-012 The block SHALL have port sample_valid, output, 1 bit: high on each cycle that new sample values are presented.
REQ-013 The block SHALL have port counter, output, WIDTH bits: up-counter sample.
REQ-014 The block SHALL have port counter_reverse, output, WIDTH bits: down-counter sample.
REQ-015 The block SHALL have port bit_rand, output, 1 bit: random bit, equal to LFSR bit 0.
REQ-016 The block SHALL have port byte_rand, output, 8 bits: random byte, equal to LFSR bits 7:0.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-018 IDLE with start=1 SHALL go to LOAD; start in any other state SHALL be ignored.
REQ-019 LOAD SHALL set counter=0, counter_reverse=0, lfsr=seed (or 1 if seed==0) and remaining=burst_len.
REQ-020 LOAD SHALL go to DONE if burst_len==0 (zero samples produced); otherwise it SHALL go to RUN.
REQ-021 Each RUN cycle without stop or pause SHALL produce one sample: counter+1, counter_reverse-1, LFSR advanced one step, remaining-1, and sample_valid=1 in the following cycle together with the new values.
REQ-022 The LFSR step SHALL be Galois right-shift: lfsr>>1, XORed with 32'h8020_0003 when the old bit 0 is 1.
REQ-023 The sample taken when remaining==1 SHALL be the last one, and the FSM SHALL then go to DONE.
REQ-024 RUN with pause=1 SHALL go to PAUSE with no sample taken that cycle; PAUSE SHALL hold all registers.
REQ-025 PAUSE with pause=0 SHALL return to RUN.
REQ-026 stop=1 in RUN or PAUSE SHALL go to DONE, with no sample taken that cycle.
REQ-027 stop SHALL have priority over pause, and pause SHALL have priority over sampling.
REQ-028 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-029 The sample values SHALL hold after DONE until the next LOAD.
REQ-030 counter SHALL wrap from 2^WIDTH-1 to 0, and counter_reverse SHALL wrap from 0 to 2^WIDTH-1, with no flag.
REQ-031 sample_valid SHALL be 0 in every state other than the cycle following a RUN sample.
REQ-032 Latency: with start at cycle N, LOAD SHALL be at N+1, the first RUN at N+2, and the first sample_valid at N+3.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE from any state, including mid-burst and PAUSE.
REQ-034 Reset values SHALL be: busy=0, done=0, sample_valid=0, counter=0, counter_reverse=0, lfsr=1, bit_rand=1, byte_rand=8'h01, remaining=0.
REQ-035 rst SHALL override start, stop and pause in the same cycle.

Structure
REQ-036 Package wave_seq_pkg SHALL hold the state enum, WIDTH, LEN_W and the LFSR tap constant LFSR_TAPS=32'h8020_0003.
REQ-037 The LFSR SHALL be a single sub-module, wave_lfsr, with ports clk, rst, load, seed, advance and value.
REQ-038 The FSM, counters and remaining counter SHALL live in wave_seq_ctrl.

Verification
REQ-039 The bench SHALL cover: reset, then start with burst_len=4, seed=1 -> four sample_valid pulses with counter 1,2,3,4 and counter_reverse FFFFFFFF..FFFFFFFC, done one cycle after the last sample, busy low after done.
REQ-040 The bench SHALL cover: burst_len=0 with start -> no sample_valid, done pulse at N+2.
REQ-041 The bench SHALL cover: burst_len=10 with pause held 3 cycles after the 2nd sample -> exactly 10 samples, no sample_valid while paused, and counter continuous with no gap.
REQ-042 The bench SHALL cover: burst_len=100 with stop asserted together with pause after sample 5 -> DONE with counter=5 held.
REQ-043 The bench SHALL cover: rst asserted mid-burst at sample 3 -> next cycle IDLE with all outputs at reset values, then a new start working normally.
REQ-044 The bench SHALL cover: seed=0 -> LFSR loads 1, byte_rand after sample 1 equals 8'h03 (1>>1 XOR 80200003), and start asserted while busy is ignored.

Source files
------------

// File: rtl/wave_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_seq_pkg
//  Description : Shared types and constants for the wave sequence controller:
//                burst FSM state encoding, default widths and LFSR taps.
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_seq_pkg;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    // Galois feedback mask applied when the bit shifted out is 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : wave_seq_pkg
`default_nettype wire

// File: rtl/wave_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : wave_lfsr
//  Description : Galois right-shift LFSR with synchronous seed load and a
//                step enable. A zero seed is replaced by 1 so the register
//                never locks up. Only the low VALUE_W bits are exported.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_lfsr #(
    parameter int WIDTH   = 32,
    parameter int VALUE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               advance,
    output logic [VALUE_W-1:0] value
);
    import wave_seq_pkg::*;

    // Taps resized to the register width (zero-extended above 32 bits)
    localparam logic [WIDTH-1:0] TAPS_W = WIDTH'(LFSR_TAPS);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Next value: seed load has priority over stepping; otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (advance) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS_W : '0);
        end
    end

    // LFSR register, resets to the non-zero value 1
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q[VALUE_W-1:0];

endmodule : wave_lfsr
`default_nettype wire

// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wave_seq_ctrl
//  Description : Burst sequencer producing up/down counter samples and LFSR
//                random values. IDLE -> LOAD -> RUN <-> PAUSE -> DONE -> IDLE.
//                Every output is a flop; sample values hold after a burst
//                until the next LOAD.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_seq_ctrl #(
    parameter int WIDTH = wave_seq_pkg::WIDTH,
    parameter int LEN_W = wave_seq_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] counter_reverse,
    output logic             bit_rand,
    output logic [7:0]       byte_rand
);
    import wave_seq_pkg::*;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] counter_rev_q, counter_rev_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sample_valid_q, sample_valid_d;

    logic             take_sample;
    logic             lfsr_load;
    logic [7:0]       lfsr_byte;

    // State and output registers; reset wins over every control input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            counter_rev_q  <= '0;
            remaining_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            counter_rev_q  <= counter_rev_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Next-state logic: stop beats pause, pause beats sampling
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = (burst_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (stop)                              state_d = ST_DONE;
                else if (pause)                        state_d = ST_PAUSE;
                else if (remaining_q == LEN_W'(1))     state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (stop)       state_d = ST_DONE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values, derived from state
    always_comb begin
        take_sample    = (state_q == ST_RUN) && !stop && !pause;
        lfsr_load      = (state_q == ST_LOAD);
        counter_d      = counter_q;
        counter_rev_d  = counter_rev_q;
        remaining_d    = remaining_q;
        if (lfsr_load) begin
            counter_d     = '0;
            counter_rev_d = '0;
            remaining_d   = burst_len;
        end else if (take_sample) begin
            // Both counters wrap silently at their limits
            counter_d     = counter_q + WIDTH'(1);
            counter_rev_d = counter_rev_q - WIDTH'(1);
            remaining_d   = remaining_q - LEN_W'(1);
        end
        busy_d         = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                         (state_d == ST_PAUSE);
        done_d         = (state_d == ST_DONE);
        sample_valid_d = take_sample;
    end

    wave_lfsr #(
        .WIDTH   (WIDTH),
        .VALUE_W (8)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (seed),
        .advance (take_sample),
        .value   (lfsr_byte)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign sample_valid    = sample_valid_q;
    assign counter         = counter_q;
    assign counter_reverse = counter_rev_q;
    assign bit_rand        = lfsr_byte[0];
    assign byte_rand       = lfsr_byte;

endmodule : wave_seq_ctrl
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_seq_ctrl
//  Description : Self-checking bench for wave_seq_ctrl: a vector table for the
//                basic burst plus directed sequences for zero length, pause,
//                stop, mid-burst reset and zero seed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [15:0] burst_len;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        sample_valid;
    logic [31:0] counter;
    logic [31:0] counter_reverse;
    logic        bit_rand;
    logic [7:0]  byte_rand;

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic        pause;
        logic [15:0] len;
        logic [31:0] seed;
        logic        busy;
        logic        done;
        logic        sv;
        logic [31:0] cnt;
        logic [31:0] rev;
        logic [7:0]  byt;
    } vec_t;

    vec_t vecs [9];

    wave_seq_ctrl #(
        .WIDTH (32),
        .LEN_W (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .pause           (pause),
        .burst_len       (burst_len),
        .seed            (seed),
        .busy            (busy),
        .done            (done),
        .sample_valid    (sample_valid),
        .counter         (counter),
        .counter_reverse (counter_reverse),
        .bit_rand        (bit_rand),
        .byte_rand       (byte_rand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] len, input logic [31:0] sd);
        burst_len = len;
        seed      = sd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    int samples;
    int exp_cnt;
    bit seen_done;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        burst_len = '0; seed = '0;

        // Basic burst: len 4, seed 1. LFSR 1->80200003->C0300002->60180001->B02C0003
        //            rst start stop pause len    seed   busy done sv  cnt  rev            byte
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0,          8'h01};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0,          8'h01};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0,          8'h01};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b1, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 8'h03};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b1, 1'b0, 1'b1, 32'd2, 32'hFFFF_FFFE, 8'h02};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b1, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFD, 8'h01};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b0, 1'b1, 1'b1, 32'd4, 32'hFFFF_FFFC, 8'h03};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b0, 1'b0, 1'b0, 32'd4, 32'hFFFF_FFFC, 8'h03};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'd1, 1'b0, 1'b0, 1'b0, 32'd4, 32'hFFFF_FFFC, 8'h03};

        for (int i = 0; i < 9; i++) begin
            rst       = vecs[i].rst;
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            pause     = vecs[i].pause;
            burst_len = vecs[i].len;
            seed      = vecs[i].seed;
            tick();
            check($sformatf("vec%0d busy", i),     32'(busy),         32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),     32'(done),         32'(vecs[i].done));
            check($sformatf("vec%0d sv", i),       32'(sample_valid), 32'(vecs[i].sv));
            check($sformatf("vec%0d cnt", i),      counter,           vecs[i].cnt);
            check($sformatf("vec%0d rev", i),      counter_reverse,   vecs[i].rev);
            check($sformatf("vec%0d byte", i),     32'(byte_rand),    32'(vecs[i].byt));
            check($sformatf("vec%0d bit", i),      32'(bit_rand),     32'(vecs[i].byt[0]));
        end

        // Zero-length burst: LOAD at N+1, done at N+2, no samples
        do_start(16'd0, 32'd1);
        check("len0 load busy", 32'(busy), 32'd1);
        check("len0 load sv", 32'(sample_valid), 32'd0);
        tick();
        check("len0 done", 32'(done), 32'd1);
        check("len0 done sv", 32'(sample_valid), 32'd0);
        check("len0 done busy", 32'(busy), 32'd0);
        tick();
        check("len0 done drop", 32'(done), 32'd0);
        check("len0 idle sv", 32'(sample_valid), 32'd0);

        // Pause for three cycles after the second sample of a 10-sample burst
        do_start(16'd10, 32'h1234_5678);
        tick();
        tick();
        check("p sample1", counter, 32'd1);
        tick();
        check("p sample2", counter, 32'd2);
        check("p sample2 sv", 32'(sample_valid), 32'd1);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("p paused sv", 32'(sample_valid), 32'd0);
            check("p paused cnt", counter, 32'd2);
            check("p paused busy", 32'(busy), 32'd1);
        end
        pause = 1'b0;
        tick();
        check("p resume sv", 32'(sample_valid), 32'd0);
        samples   = 2;
        exp_cnt   = 3;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (sample_valid) begin
                check("p continuous cnt", counter, 32'(exp_cnt));
                exp_cnt++;
                samples++;
            end
            if (done) seen_done = 1'b1;
        end
        check("p sample total", 32'(samples), 32'd10);
        check("p done seen", 32'(seen_done), 32'd1);
        tick();
        check("p idle busy", 32'(busy), 32'd0);

        // Stop together with pause after sample 5 of a 100-sample burst
        do_start(16'd100, 32'd1);
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("s sample5", counter, 32'd5);
        stop  = 1'b1;
        pause = 1'b1;
        tick();
        stop  = 1'b0;
        pause = 1'b0;
        check("s done", 32'(done), 32'd1);
        check("s sv", 32'(sample_valid), 32'd0);
        check("s cnt", counter, 32'd5);
        check("s busy", 32'(busy), 32'd0);
        tick();
        check("s done drop", 32'(done), 32'd0);
        check("s cnt held", counter, 32'd5);
        check("s rev held", counter_reverse, 32'hFFFF_FFFB);

        // Reset mid-burst at sample 3, with every control input also high
        do_start(16'd10, 32'd1);
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("r sample3", counter, 32'd3);
        rst = 1'b1; start = 1'b1; stop = 1'b1; pause = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        check("r busy", 32'(busy), 32'd0);
        check("r done", 32'(done), 32'd0);
        check("r sv", 32'(sample_valid), 32'd0);
        check("r cnt", counter, 32'd0);
        check("r rev", counter_reverse, 32'd0);
        check("r byte", 32'(byte_rand), 32'h01);
        check("r bit", 32'(bit_rand), 32'd1);
        tick();
        check("r stays idle", 32'(busy), 32'd0);
        do_start(16'd2, 32'd1);
        check("r2 load busy", 32'(busy), 32'd1);
        tick();
        check("r2 run sv", 32'(sample_valid), 32'd0);
        tick();
        check("r2 s1 sv", 32'(sample_valid), 32'd1);
        check("r2 s1 cnt", counter, 32'd1);
        check("r2 s1 byte", 32'(byte_rand), 32'h03);
        tick();
        check("r2 s2 cnt", counter, 32'd2);
        check("r2 s2 byte", 32'(byte_rand), 32'h02);
        check("r2 done", 32'(done), 32'd1);
        tick();
        check("r2 idle busy", 32'(busy), 32'd0);
        check("r2 idle sv", 32'(sample_valid), 32'd0);

        // Zero seed loads 1; start while busy is ignored
        do_start(16'd3, 32'd0);
        tick();
        check("z loaded byte", 32'(byte_rand), 32'h01);
        start = 1'b1;
        tick();
        check("z s1 cnt", counter, 32'd1);
        check("z s1 byte", 32'(byte_rand), 32'h03);
        tick();
        check("z s2 cnt", counter, 32'd2);
        check("z s2 byte", 32'(byte_rand), 32'h02);
        check("z s2 busy", 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        check("z s3 cnt", counter, 32'd3);
        check("z s3 byte", 32'(byte_rand), 32'h01);
        check("z done", 32'(done), 32'd1);
        tick();
        check("z idle busy", 32'(busy), 32'd0);
        tick();
        check("z still idle", 32'(busy), 32'd0);
        check("z cnt held", counter, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wave_seq_ctrl
`default_nettype wire
